// File: rtl/mips_pkg.sv
// Shared encodings, FSM states and decoded-instruction record for the
// multi-cycle MIPS-subset core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_READ, ST_EXEC, ST_WB, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [15:0] imm;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        is_branch;
    logic        valid;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.rs        = ir[25:21];
    d.rt        = ir[20:16];
    d.dest      = 5'd0;
    d.imm       = ir[15:0];
    d.alu_op    = ALU_ADD;
    d.use_imm   = 1'b0;
    d.is_branch = 1'b0;
    d.valid     = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        d.dest  = ir[15:11];
        d.valid = 1'b1;
        case (ir[5:0])
          FN_ADDU: d.alu_op = ALU_ADD;
          FN_SUBU: d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_SLT:  d.alu_op = ALU_SLT;
          default: d.valid  = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        d.dest    = ir[20:16];
        d.use_imm = 1'b1;
        d.valid   = 1'b1;
      end
      // beq reuses the ALU only for its equality output
      OP_BEQ: begin
        d.is_branch = 1'b1;
        d.valid     = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: add/sub/and/or/signed set-less-than plus an equality flag.
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           alu_op,
  output logic [DATA_W-1:0] result,
  output logic              eq
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/mips_multicycle_core.sv
// Five-state-per-instruction MIPS-subset core with loadable instruction
// memory, start/done handshake, sticky illegal flag and retired counter.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int IMEM_DEPTH = 8,
  parameter  int CNT_W      = 16,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [31:0]       imem_wdata,
  input  logic [PC_W:0]     max_pc,
  input  logic              start,
  input  logic [4:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_q;
  logic [PC_W:0]     pc_q, max_pc_q, pc_d, br_off;
  logic [31:0]       ir_q;
  dec_t              dec_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, alu_b, alu_res;
  logic              taken_q, busy_q, done_q, illegal_q, alu_eq, idle_or_done;
  logic [CNT_W-1:0]  retired_q;
  logic [DATA_W-1:0] rf_q [32];
  logic [31:0]       imem_q [IMEM_DEPTH];

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign alu_b        = dec_q.use_imm ? DATA_W'($signed(dec_q.imm)) : b_q;
  // Branch target arithmetic wraps in PC_W+1 bits so it can be compared to max_pc
  assign br_off       = (PC_W+1)'($signed(dec_q.imm));
  assign pc_d         = pc_q + (PC_W+1)'(1) + (taken_q ? br_off : '0);

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .alu_op (dec_q.alu_op),
    .result (alu_res),
    .eq     (alu_eq)
  );

  always_ff @(posedge clk) begin
    if (imem_we && idle_or_done) imem_q[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      max_pc_q  <= '0;
      ir_q      <= '0;
      dec_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      taken_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pc_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            max_pc_q  <= max_pc;
            if (max_pc == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          ir_q    <= imem_q[pc_q[PC_W-1:0]];
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          dec_q   <= decode(ir_q);
          state_q <= ST_READ;
        end
        ST_READ: begin
          a_q     <= rf_q[dec_q.rs];
          b_q     <= rf_q[dec_q.rt];
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_res;
          taken_q <= dec_q.is_branch && alu_eq;
          state_q <= ST_WB;
        end
        ST_WB: begin
          if (!dec_q.valid) illegal_q <= 1'b1;
          if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
          pc_q <= pc_d;
          if (pc_d >= max_pc_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (state_q == ST_WB && dec_q.valid && !dec_q.is_branch && dec_q.dest != 5'd0) begin
      rf_q[dec_q.dest] <= res_q;
    end
  end

  assign out_data = (out_addr == 5'd0) ? '0 : rf_q[out_addr];
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench driving an 8-bit and a 16-bit core with identical stimulus and
// checking both against an instruction-level reference model every cycle.
module tb_mips_multicycle_core;

  localparam int IMEM_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [2:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [3:0]  max_pc;
  logic        start;
  logic [4:0]  out_addr;
  logic [7:0]  od8;
  logic [15:0] od16;
  logic        busy8, done8, ill8, busy16, done16, ill16;
  logic [15:0] ret8, ret16;

  always #5 clk = ~clk;

  mips_multicycle_core #(.DATA_W(8), .IMEM_DEPTH(IMEM_DEPTH), .CNT_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .max_pc(max_pc), .start(start), .out_addr(out_addr),
    .out_data(od8), .busy(busy8), .done(done8), .illegal(ill8), .retired(ret8)
  );

  mips_multicycle_core #(.DATA_W(16), .IMEM_DEPTH(IMEM_DEPTH), .CNT_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .max_pc(max_pc), .start(start), .out_addr(out_addr),
    .out_data(od16), .busy(busy16), .done(done16), .illegal(ill16), .retired(ret16)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 is the 8-bit core, index 1 the 16-bit core
  logic [31:0] prog [IMEM_DEPTH];
  longint      m_rf [2][32];
  int          m_pc [2];
  int          m_ret [2];
  int          m_ph [2];
  bit          m_run [2];
  bit          m_done [2];
  bit          m_ill [2];
  int          m_max;

  function automatic logic [31:0] enc_addiu(int rt, int rs, int imm);
    return {6'b001001, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(int fn, int rd, int rs, int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_beq(int rs, int rt, int off);
    return {6'b000100, 5'(rs), 5'(rt), 16'(off)};
  endfunction

  function automatic longint sx(longint v, int w);
    longint half;
    half = longint'(1) << (w - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_done[k] = 1'b0; m_ill[k] = 1'b0;
      m_ret[k] = 0; m_pc[k] = 0; m_ph[k] = 0;
      for (int r = 0; r < 32; r++) m_rf[k][r] = 0;
    end
  endtask

  task automatic model_start(input int maxpc);
    m_max = maxpc;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_ill[k] = 1'b0; m_ret[k] = 0; m_ph[k] = 0;
      m_run[k]  = (maxpc != 0);
      m_done[k] = (maxpc == 0);
    end
  endtask

  task automatic model_exec(input int k);
    int          w, dest, npc;
    longint      mask, a, b, r, simm;
    logic [31:0] ins;
    bit          wr, taken;
    w    = (k != 0) ? 16 : 8;
    mask = (longint'(1) << w) - 1;
    ins  = prog[m_pc[k] % IMEM_DEPTH];
    a    = m_rf[k][ins[25:21]];
    b    = m_rf[k][ins[20:16]];
    simm = sx(longint'(ins[15:0]), 16);
    wr = 1'b0; taken = 1'b0; dest = 0; r = 0;
    if (ins[31:26] == 6'd0 && ins[5:0] inside {6'd33, 6'd35, 6'd36, 6'd37, 6'd42}) begin
      dest = int'(ins[15:11]);
      wr   = 1'b1;
      case (ins[5:0])
        6'd33:   r = a + b;
        6'd35:   r = a - b;
        6'd36:   r = a & b;
        6'd37:   r = a | b;
        default: r = (sx(a, w) < sx(b, w)) ? 1 : 0;
      endcase
    end else if (ins[31:26] == 6'd9) begin
      dest = int'(ins[20:16]);
      wr   = 1'b1;
      r    = a + simm;
    end else if (ins[31:26] == 6'd4) begin
      taken = (a == b);
    end else begin
      m_ill[k] = 1'b1;
    end
    if (wr && dest != 0) m_rf[k][dest] = r & mask;
    npc = m_pc[k] + 1 + (taken ? int'(simm) : 0);
    npc = ((npc % 16) + 16) % 16;
    m_pc[k] = npc;
    if (m_ret[k] < 65535) m_ret[k]++;
    if (npc >= m_max) begin
      m_run[k]  = 1'b0;
      m_done[k] = 1'b1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_run[k]) begin
        m_ph[k]++;
        if (m_ph[k] == 5) begin
          m_ph[k] = 0;
          model_exec(k);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("busy_w8",    64'(busy8),  64'(m_run[0]));
    chk("done_w8",    64'(done8),  64'(m_done[0]));
    chk("illegal_w8", 64'(ill8),   64'(m_ill[0]));
    chk("retired_w8", 64'(ret8),   64'(m_ret[0]));
    chk("out_w8",     64'(od8),    m_rf[0][out_addr]);
    chk("busy_w16",    64'(busy16), 64'(m_run[1]));
    chk("done_w16",    64'(done16), 64'(m_done[1]));
    chk("illegal_w16", 64'(ill16),  64'(m_ill[1]));
    chk("retired_w16", 64'(ret16),  64'(m_ret[1]));
    chk("out_w16",     64'(od16),   m_rf[1][out_addr]);
  endtask

  task automatic scan_regs(input string tag);
    for (int r = 0; r < 32; r++) begin
      out_addr = 5'(r);
      #1;
      chk($sformatf("%s_r%0d_w8", tag, r),  64'(od8),  m_rf[0][r]);
      chk($sformatf("%s_r%0d_w16", tag, r), 64'(od16), m_rf[1][r]);
    end
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = 3'(i);
      imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // Starts a run and follows it cycle by cycle; optional busy-time write,
  // busy-time start and mid-run reset at the given cycle indices (-1 = none).
  task automatic run(input int maxpc, input int we_cyc, input int st_cyc,
                     input int rst_cyc, output int edges);
    int cyc;
    @(negedge clk);
    max_pc = 4'(maxpc);
    start  = 1'b1;
    @(posedge clk);
    model_start(maxpc);
    @(negedge clk);
    start = 1'b0;
    check_all();
    cyc = 0;
    while ((m_run[0] || m_run[1]) && cyc < 300) begin
      if (cyc == we_cyc) begin
        imem_we    = 1'b1;
        imem_waddr = 3'd2;
        imem_wdata = enc_addiu(2, 1, 100);
      end
      if (cyc == st_cyc) start = 1'b1;
      if (cyc == rst_cyc) begin
        chk("busy_before_reset", 64'(busy8), 64'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
        break;
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      imem_we = 1'b0;
      start   = 1'b0;
      check_all();
      cyc++;
    end
    if (m_run[0] || m_run[1]) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: still busy after %0d cycles, required done", cyc);
    end
    edges = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    reset = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    max_pc = '0; start = 1'b0; out_addr = 5'd0;
    model_reset();
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Reference program: $5 = (45 + -20) - (-60 + 30) = 55
    prog[0] = enc_addiu(1, 0, 45);
    prog[1] = enc_addiu(2, 0, -20);
    prog[2] = enc_addiu(3, 0, -60);
    prog[3] = enc_addiu(4, 0, 30);
    prog[4] = enc_r(33, 5, 1, 2);
    prog[5] = enc_r(33, 6, 3, 4);
    prog[6] = enc_r(35, 5, 5, 6);
    load_prog(7);
    out_addr = 5'd5;
    run(7, -1, -1, -1, e);
    chk("ref_done_edge", 64'(e), 64'd35);
    chk("ref_r5_w8", 64'(od8), 64'd55);
    chk("ref_r5_w16", 64'(od16), 64'd55);
    chk("ref_model_r5", m_rf[0][5], 64'd55);
    chk("ref_retired", 64'(ret8), 64'd7);
    chk("ref_illegal", 64'(ill8), 64'd0);
    scan_regs("ref");

    // slt / and / or, and a write aimed at $0; a start pulse while busy is ignored
    prog[0] = enc_addiu(1, 0, -1);
    prog[1] = enc_addiu(2, 0, 2);
    prog[2] = enc_r(42, 3, 1, 2);
    prog[3] = enc_r(42, 4, 2, 1);
    prog[4] = enc_r(36, 5, 1, 2);
    prog[5] = enc_r(37, 6, 1, 2);
    prog[6] = enc_addiu(0, 0, 5);
    load_prog(7);
    out_addr = 5'd6;
    run(7, -1, 7, -1, e);
    chk("logic_done_edge", 64'(e), 64'd35);
    chk("or_r6_w16", 64'(od16), 64'hFFFF);
    chk("or_r6_w8", 64'(od8), 64'hFF);
    out_addr = 5'd3; #1;
    chk("slt_r3_w16", 64'(od16), 64'd1);
    out_addr = 5'd4; #1;
    chk("slt_r4_w16", 64'(od16), 64'd0);
    out_addr = 5'd5; #1;
    chk("and_r5_w16", 64'(od16), 64'd2);
    out_addr = 5'd0; #1;
    chk("r0_w16", 64'(od16), 64'd0);
    scan_regs("logic");

    // beq countdown loop: 1 + 3 + 3 + 2 = 9 instructions
    prog[0] = enc_addiu(1, 0, 3);
    prog[1] = enc_addiu(1, 1, -1);
    prog[2] = enc_beq(1, 0, 1);
    prog[3] = enc_beq(0, 0, -3);
    load_prog(4);
    out_addr = 5'd1;
    run(4, -1, -1, -1, e);
    chk("loop_done_edge", 64'(e), 64'd45);
    chk("loop_r1_w8", 64'(od8), 64'd0);
    chk("loop_retired", 64'(ret16), 64'd9);
    chk("loop_done", 64'(done16), 64'd1);
    scan_regs("loop");

    // Illegal word in the middle, plus an imem write attempted while busy
    prog[0] = enc_addiu(1, 0, 7);
    prog[1] = 32'hFC000000;
    prog[2] = enc_addiu(2, 1, 1);
    load_prog(3);
    out_addr = 5'd2;
    run(3, 1, -1, -1, e);
    chk("ill_flag", 64'(ill8), 64'd1);
    chk("ill_retired", 64'(ret8), 64'd3);
    chk("ill_r2_w16", 64'(od16), 64'd8);
    scan_regs("ill");

    // max_pc = 0 goes straight to DONE and clears the sticky flag
    run(0, -1, -1, -1, e);
    chk("zero_done", 64'(done8), 64'd1);
    chk("zero_illegal", 64'(ill16), 64'd0);
    chk("zero_retired", 64'(ret16), 64'd0);

    // Reset while instruction 3 is in EXEC, then rerun from scratch
    prog[0] = enc_addiu(1, 0, 45);
    prog[1] = enc_addiu(2, 0, -20);
    prog[2] = enc_addiu(3, 0, -60);
    prog[3] = enc_addiu(4, 0, 30);
    prog[4] = enc_r(33, 5, 1, 2);
    prog[5] = enc_r(33, 6, 3, 4);
    prog[6] = enc_r(35, 5, 5, 6);
    load_prog(7);
    out_addr = 5'd1;
    run(7, -1, -1, 13, e);
    chk("rst_busy", 64'(busy16), 64'd0);
    scan_regs("rst");
    out_addr = 5'd5;
    run(7, -1, -1, -1, e);
    chk("rerun_done_edge", 64'(e), 64'd35);
    chk("rerun_r5_w8", 64'(od8), 64'd55);
    chk("rerun_r5_w16", 64'(od16), 64'd55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
